fft_sync_fifo: RTL and testbench

FFT_SYNC_FIFO -- requirements
Module: fft_sync_fifo

---
 rtl/fft_sync_fifo.sv | 147 ++++++++++++++
 tb/tb_fft_sync_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fft_sync_fifo.sv
// fft_sync_fifo: single-clock FIFO with a registered read port, occupancy
// count, full/empty and almost-full/almost-empty flags, and one-cycle
// overflow/underflow pulses for rejected requests.
module fft_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_V    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_V    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);

    // Storage array: one write port, one read port, never reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_acc_s;
    logic                  rd_acc_s;

    // Accept decisions come from the registered count, so a full FIFO can
    // still pop while refusing the write, and an empty FIFO can still push
    // while refusing the read (no show-ahead).
    always_comb begin
        wr_acc_s = wr_en && (count_q != DEPTH_V);
        rd_acc_s = rd_en && (count_q != CNT_ZERO);
    end

    // Next-state for pointers, count, read port and status flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = wr_en && !wr_acc_s;
        underflow_d = rd_en && !rd_acc_s;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Flags are registered alongside count, so they always agree with it.
        full_d   = (count_d == DEPTH_V);
        empty_d  = (count_d == CNT_ZERO);
        afull_d  = (count_d >= AF_V);
        aempty_d = (count_d <= AE_V);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            rd_data_q   <= {DATA_WIDTH{1'b0}};
            rd_valid_q  <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port; reset wins so a reset cycle stores nothing.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fft_sync_fifo.sv
// Directed self-checking bench for fft_sync_fifo with default parameters.
module tb_fft_sync_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int tests_run = 0;
    int tests_failed = 0;

    fft_sync_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 32'h0;
        step();
        step();
        rst = 1'b0;
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_aempty", {31'd0, almost_empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_afull", {31'd0, almost_full}, 32'd0);
        check("rst_rdvalid", {31'd0, rd_valid}, 32'd0);
        check("rst_rddata", rd_data, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_unf", {31'd0, underflow}, 32'd0);

        // Fill with 0x1..0x10.
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 32'(i);
            step();
            check("fill_count", {27'd0, count}, 32'(i));
            check("fill_afull", {31'd0, almost_full}, (i >= 14) ? 32'd1 : 32'd0);
            check("fill_full", {31'd0, full}, (i == 16) ? 32'd1 : 32'd0);
            check("fill_aempty", {31'd0, almost_empty}, (i <= 2) ? 32'd1 : 32'd0);
            check("fill_empty", {31'd0, empty}, 32'd0);
        end
        wr_data = 32'h99;
        step();
        check("ovf_pulse", {31'd0, overflow}, 32'd1);
        check("ovf_count", {27'd0, count}, 32'd16);
        wr_en = 1'b0;
        step();
        check("ovf_clear", {31'd0, overflow}, 32'd0);

        // Drain: 0x1..0x10 in order, one cycle after each request.
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            step();
            check("drain_data", rd_data, 32'(i));
            check("drain_valid", {31'd0, rd_valid}, 32'd1);
            check("drain_count", {27'd0, count}, 32'(16 - i));
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        step();
        check("unf_pulse", {31'd0, underflow}, 32'd1);
        check("unf_valid", {31'd0, rd_valid}, 32'd0);
        check("unf_hold", rd_data, 32'h10);
        rd_en = 1'b0;
        step();
        check("unf_clear", {31'd0, underflow}, 32'd0);
        check("idle_hold", rd_data, 32'h10);

        // Simultaneous request while empty: write wins, read refused.
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hAA;
        step();
        check("ewr_count", {27'd0, count}, 32'd1);
        check("ewr_valid", {31'd0, rd_valid}, 32'd0);
        check("ewr_unf", {31'd0, underflow}, 32'd1);
        wr_en = 1'b0;
        step();
        check("ewr_data", rd_data, 32'hAA);
        check("ewr_valid2", {31'd0, rd_valid}, 32'd1);
        check("ewr_count2", {27'd0, count}, 32'd0);
        rd_en = 1'b0;

        // Steady state at count 5 across the pointer wrap.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 32'h100 + 32'(i);
            step();
        end
        check("ss_pre_count", {27'd0, count}, 32'd5);
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h105 + 32'(k);
            step();
            check("ss_count", {27'd0, count}, 32'd5);
            check("ss_data", rd_data, 32'h100 + 32'(k));
            check("ss_valid", {31'd0, rd_valid}, 32'd1);
        end
        rd_en = 1'b0;

        // Refill to full (holds 0x114..0x118 then 0x200..0x20A).
        for (int i = 0; i < 11; i++) begin
            wr_en = 1'b1; wr_data = 32'h200 + 32'(i);
            step();
        end
        check("refill_full", {31'd0, full}, 32'd1);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h55;
        step();
        check("fwr_count", {27'd0, count}, 32'd15);
        check("fwr_ovf", {31'd0, overflow}, 32'd1);
        check("fwr_data", rd_data, 32'h114);
        check("fwr_valid", {31'd0, rd_valid}, 32'd1);
        check("fwr_full", {31'd0, full}, 32'd0);
        wr_en = 1'b0;

        // Drain to 8 (next words 0x115..0x118, then 0x200..).
        for (int i = 0; i < 7; i++) begin
            step();
            check("d8_data", rd_data, (i < 4) ? (32'h115 + 32'(i)) : (32'h200 + 32'(i - 4)));
        end
        rd_en = 1'b0;
        step();
        check("d8_count", {27'd0, count}, 32'd8);

        // Reset alongside requests.
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h77;
        step();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check("mrst_count", {27'd0, count}, 32'd0);
        check("mrst_empty", {31'd0, empty}, 32'd1);
        check("mrst_valid", {31'd0, rd_valid}, 32'd0);
        check("mrst_data", rd_data, 32'd0);
        check("mrst_ovf", {31'd0, overflow}, 32'd0);
        check("mrst_unf", {31'd0, underflow}, 32'd0);

        // Post-reset round trip.
        wr_en = 1'b1; wr_data = 32'h33;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("post_data", rd_data, 32'h33);
        check("post_valid", {31'd0, rd_valid}, 32'd1);
        check("post_empty", {31'd0, empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
